uart_packet_decoder: RTL and testbench

UART_PACKET_DECODER -- requirements
Module: uart_packet_decoder

---
 rtl/uart_packet_decoder.sv | 97 +++++++++
 tb/tb_uart_packet_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_packet_decoder.sv
// uart_packet_decoder: SYNC_BYTE, LEN, payload framing into a readout buffer.
// Define UART_PKT_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module uart_packet_decoder #(
   parameter logic [7:0] SYNC_BYTE = 8'hAA,
   parameter int MAX_LEN = 16
) (
   input  logic       CLK_i,
   input  logic       Reset_i,
   input  logic       byte_valid_i,
   input  logic [7:0] byte_i,
   input  logic       rd_en_i,
   output logic       pkt_valid_o,
   output logic [4:0] pkt_len_o,
   output logic [7:0] rd_data_o,
   output logic       err_o,
   output logic [1:0] err_code_o
);
`ifdef UART_PKT_CHECKSUM_EN
   typedef enum logic [2:0] {HUNT, LEN, DATA, CHK, OUT} state_t;
   logic [7:0] sum;
`else
   typedef enum logic [2:0] {HUNT, LEN, DATA, OUT} state_t;
`endif
   localparam logic [7:0] MAX = 8'(MAX_LEN);
   state_t state, state_n;
   logic [4:0] len, wr_ptr, rd_ptr;
   logic [7:0] mem [32];
   logic err_n;
   logic [1:0] code_n;
   assign pkt_valid_o = state == OUT;
   assign pkt_len_o = len;
   assign rd_data_o = mem[rd_ptr];
   always_comb begin
      state_n = state;
      err_n = 1'b0;
      code_n = err_code_o;
      case (state)
         HUNT: if (byte_valid_i && byte_i == SYNC_BYTE) state_n = LEN;
         LEN: if (byte_valid_i) begin
            if (byte_i == 8'd0 || byte_i > MAX) begin
               state_n = HUNT;
               err_n = 1'b1;
               code_n = 2'b01;
            end else state_n = DATA;
         end
`ifdef UART_PKT_CHECKSUM_EN
         DATA: if (byte_valid_i && wr_ptr == len - 5'd1) state_n = CHK;
         CHK: if (byte_valid_i) begin
            state_n = byte_i == sum ? OUT : HUNT;
            err_n = byte_i != sum;
            code_n = byte_i != sum ? 2'b10 : err_code_o;
         end
`else
         DATA: if (byte_valid_i && wr_ptr == len - 5'd1) state_n = OUT;
`endif
         OUT: begin
            // a byte arriving while a frame is held is lost, even on the final read
            if (rd_en_i && rd_ptr == len - 5'd1) state_n = HUNT;
            if (byte_valid_i) begin
               err_n = 1'b1;
               code_n = 2'b11;
            end
         end
         default: state_n = HUNT;
      endcase
   end
   always_ff @(posedge CLK_i or posedge Reset_i)
      if (Reset_i) begin
         state <= HUNT;
         len <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         err_o <= 1'b0;
         err_code_o <= 2'b00;
`ifdef UART_PKT_CHECKSUM_EN
         sum <= '0;
`endif
      end else begin
         state <= state_n;
         err_o <= err_n;
         err_code_o <= code_n;
         if (state == LEN && state_n == DATA) begin
            len <= byte_i[4:0];
            wr_ptr <= '0;
         end
         if (state == DATA && byte_valid_i) wr_ptr <= wr_ptr + 5'd1;
         if (state == HUNT) rd_ptr <= '0;
         else if (state == OUT && rd_en_i) rd_ptr <= rd_ptr + 5'd1;
`ifdef UART_PKT_CHECKSUM_EN
         if (state == HUNT) sum <= '0;
         else if (state == LEN && byte_valid_i) sum <= byte_i;
         else if (state == DATA && byte_valid_i) sum <= sum + byte_i;
`endif
      end
   always_ff @(posedge CLK_i)
      if (state == DATA && byte_valid_i) mem[wr_ptr] <= byte_i;
endmodule

// File: tb/tb_uart_packet_decoder.sv
// tb_uart_packet_decoder: directed frames with hand-computed results.
// Follows UART_PKT_CHECKSUM_EN to append checksum bytes where needed.
module tb_uart_packet_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic byte_valid = 1'b0;
   logic [7:0] byte_in = '0;
   logic rd_en = 1'b0;
   logic pkt_valid;
   logic [4:0] pkt_len;
   logic [7:0] rd_data;
   logic err;
   logic [1:0] err_code;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   uart_packet_decoder dut (
      .CLK_i(clk),
      .Reset_i(rst),
      .byte_valid_i(byte_valid),
      .byte_i(byte_in),
      .rd_en_i(rd_en),
      .pkt_valid_o(pkt_valid),
      .pkt_len_o(pkt_len),
      .rd_data_o(rd_data),
      .err_o(err),
      .err_code_o(err_code)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic put(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_in = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask
   task automatic pop();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask
   task automatic csum(input logic [7:0] c);
`ifdef UART_PKT_CHECKSUM_EN
      put(c);
`else
      if (c == 8'hFF) put(c);
`endif
   endtask
   initial begin
      logic [7:0] s;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(pkt_valid), 0);
      chk("rst_len", 32'(pkt_len), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_code", 32'(err_code), 0);
      rst = 1'b0;
      @(negedge clk);
      put(8'hAA); put(8'h03); put(8'h11); put(8'h22); put(8'h33); csum(8'h69);
      chk("f1_valid", 32'(pkt_valid), 1);
      chk("f1_len", 32'(pkt_len), 3);
      chk("f1_d0", 32'(rd_data), 32'h11);
      pop();
      chk("f1_d1", 32'(rd_data), 32'h22);
      pop();
      chk("f1_d2", 32'(rd_data), 32'h33);
      chk("f1_valid_mid", 32'(pkt_valid), 1);
      pop();
      chk("f1_done", 32'(pkt_valid), 0);
      pop();
      chk("idle_rd_ignored_err", 32'(err), 0);
`ifdef UART_PKT_CHECKSUM_EN
      put(8'hAA); put(8'h02); put(8'h10); put(8'h20); put(8'h32);
      chk("ck_ok_valid", 32'(pkt_valid), 1);
      chk("ck_ok_err", 32'(err), 0);
      pop(); pop();
      put(8'hAA); put(8'h02); put(8'h10); put(8'h20); put(8'h33);
      chk("ck_bad_err", 32'(err), 1);
      chk("ck_bad_code", 32'(err_code), 2);
      chk("ck_bad_valid", 32'(pkt_valid), 0);
`endif
      put(8'h55); put(8'hAA);
      chk("sync_no_err", 32'(err), 0);
      put(8'h00);
      chk("len0_err", 32'(err), 1);
      chk("len0_code", 32'(err_code), 1);
      put(8'hAA);
      chk("len0_pulse", 32'(err), 0);
      put(8'h11);
      chk("len17_err", 32'(err), 1);
      chk("len17_code", 32'(err_code), 1);
      chk("len17_valid", 32'(pkt_valid), 0);
      @(negedge clk);
      chk("code_hold_err", 32'(err), 0);
      chk("code_hold", 32'(err_code), 1);
      put(8'hAA); put(8'h02); put(8'h5A); put(8'hA5); csum(8'h01);
      chk("ov_valid", 32'(pkt_valid), 1);
      put(8'hAA);
      chk("ov_err", 32'(err), 1);
      chk("ov_code", 32'(err_code), 3);
      chk("ov_valid_kept", 32'(pkt_valid), 1);
      chk("ov_len", 32'(pkt_len), 2);
      chk("ov_d0", 32'(rd_data), 32'h5A);
      pop();
      chk("ov_d1", 32'(rd_data), 32'hA5);
      pop();
      chk("ov_done", 32'(pkt_valid), 0);
      put(8'hAA); put(8'h01); put(8'h44); csum(8'h45);
      chk("race_valid", 32'(pkt_valid), 1);
      rd_en = 1'b1;
      put(8'hAA);
      rd_en = 1'b0;
      chk("race_err", 32'(err), 1);
      chk("race_code", 32'(err_code), 3);
      chk("race_valid_off", 32'(pkt_valid), 0);
      put(8'hAA); put(8'h01); put(8'h33); csum(8'h34);
      chk("race_next_valid", 32'(pkt_valid), 1);
      chk("race_next_data", 32'(rd_data), 32'h33);
      pop();
      put(8'hAA); put(8'h04); put(8'h01); put(8'h02);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(pkt_valid), 0);
      chk("mid_rst_len", 32'(pkt_len), 0);
      chk("mid_rst_err", 32'(err), 0);
      chk("mid_rst_code", 32'(err_code), 0);
      @(negedge clk);
      rst = 1'b0;
      put(8'hAA); put(8'h01); put(8'h7F); csum(8'h80);
      chk("post_rst_valid", 32'(pkt_valid), 1);
      chk("post_rst_len", 32'(pkt_len), 1);
      chk("post_rst_data", 32'(rd_data), 32'h7F);
      pop();
      chk("post_rst_done", 32'(pkt_valid), 0);
      put(8'hAA); put(8'h10);
      s = 8'h10;
      for (int i = 0; i < 16; i++) begin
         put(8'(i * 7 + 3));
         s = s + 8'(i * 7 + 3);
      end
      csum(s);
      chk("b2b_valid", 32'(pkt_valid), 1);
      chk("b2b_len", 32'(pkt_len), 16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("b2b_d%0d", i), 32'(rd_data), 32'(8'(i * 7 + 3)));
         pop();
      end
      chk("b2b_done", 32'(pkt_valid), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
